pcm_serial_tx: RTL and testbench

- Serial PCM audio transmitter; the transmit counterpart of the microphone deserializer.
- Accepts parallel left/right sample pairs over a valid/ready handshake.
- Generates bit clock sclk, word select ws and MSB-first serial data sdata toward an external DAC/amplifier or loopback receiver.
- Sits between the audio sample source (FIFO/test pattern) and the board audio pins; runs entirely in the mclk domain.

---
 rtl/pcm_audio_pkg.sv | 15 +
 rtl/pcm_bclk_gen.sv | 40 ++++
 rtl/pcm_serial_tx.sv | 164 ++++++++++++++++
 tb/tb_pcm_serial_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pcm_audio_pkg.sv
// Shared constants and types for the PCM audio transmit path.
package pcm_audio_pkg;

    localparam int unsigned DefWidth     = 16;
    localparam int unsigned DefBitCycles = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StLeft  = 2'd1;
    localparam state_t StRight = 2'd2;

    typedef logic [DefWidth-1:0] sample_t;

endpackage

// File: rtl/pcm_bclk_gen.sv
// Serial bit clock generator: divides mclk by BIT_CYCLES while enabled, held at phase 0 otherwise.
module pcm_bclk_gen
    import pcm_audio_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = DefBitCycles
) (
    input  logic mclk,
    input  logic reset,
    input  logic en_i,
    output logic sclk_o,
    output logic bit_tick_o
);

    localparam int unsigned CntW = $clog2(BIT_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(BIT_CYCLES / 2);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!en_i || (div_cnt_q == LastCnt)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign sclk_o     = (div_cnt_q >= HalfCnt);
    assign bit_tick_o = en_i && (div_cnt_q == LastCnt);

endmodule

// File: rtl/pcm_serial_tx.sv
// Serial PCM transmitter: one-entry sample buffer, left/right shift FSM, MSB-first output.
// Define PCM_TX_I2S_DELAY_EN for I2S framing (data one bit slot behind ws).
module pcm_serial_tx
    import pcm_audio_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned BIT_CYCLES = DefBitCycles
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_left,
    input  logic [WIDTH-1:0] s_right,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             sclk,
    output logic             ws,
    output logic             sdata,
    output logic             underrun
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [WIDTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
    logic             ws_q, ws_d;
    logic             sdata_q, sdata_d;
    logic             underrun_q, underrun_d;
    logic             bit_tick;

    pcm_bclk_gen #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bclk_gen (
        .mclk       (mclk),
        .reset      (reset),
        .en_i       (state_q != StIdle),
        .sclk_o     (sclk),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        bit_idx_d  = bit_idx_q;
        ws_d       = ws_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;

        // Transfer and consumption are mutually exclusive: one needs the buffer empty, one full.
        if (s_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_l_d    = s_left;
            buf_r_d    = s_right;
        end

        unique case (state_q)
            StIdle: begin
                if (buf_full_q) begin
                    state_d    = StLeft;
                    shift_l_d  = buf_l_q;
                    shift_r_d  = buf_r_q;
                    buf_full_d = 1'b0;
                    bit_idx_d  = '0;
                    ws_d       = 1'b0;
                    sdata_d    = buf_l_q[WIDTH-1];
                end
            end
            StLeft: begin
                if (bit_tick) begin
                    if (bit_idx_q == LastIdx) begin
                        state_d   = StRight;
                        bit_idx_d = '0;
                        ws_d      = 1'b1;
                        sdata_d   = shift_r_q[WIDTH-1];
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_l_d = shift_l_q << 1;
                        sdata_d   = shift_l_q[WIDTH-2];
                    end
                end
            end
            StRight: begin
                if (bit_tick) begin
                    if (bit_idx_q == LastIdx) begin
                        state_d   = StLeft;
                        bit_idx_d = '0;
                        ws_d      = 1'b0;
                        if (buf_full_q) begin
                            shift_l_d  = buf_l_q;
                            shift_r_d  = buf_r_q;
                            buf_full_d = 1'b0;
                            sdata_d    = buf_l_q[WIDTH-1];
                        end else begin
                            shift_l_d  = '0;
                            shift_r_d  = '0;
                            sdata_d    = 1'b0;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_r_d = shift_r_q << 1;
                        sdata_d   = shift_r_q[WIDTH-2];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q    <= StIdle;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            shift_l_q  <= '0;
            shift_r_q  <= '0;
            bit_idx_q  <= '0;
            ws_q       <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            bit_idx_q  <= bit_idx_d;
            ws_q       <= ws_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef PCM_TX_I2S_DELAY_EN
    // One-slot delay: each word's LSB spills into the first slot of the following word.
    logic dly_q;

    always_ff @(posedge mclk) begin
        if (reset) begin
            dly_q <= 1'b0;
        end else if (bit_tick) begin
            dly_q <= sdata_q;
        end
    end

    assign sdata = dly_q;
`else
    assign sdata = sdata_q;
`endif

    assign s_ready  = !buf_full_q;
    assign ws       = ws_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_pcm_serial_tx.sv
// Directed bench for pcm_serial_tx: idle, single pair, streaming, underrun, mid-frame reset.
module tb_pcm_serial_tx;
    import pcm_audio_pkg::*;

    localparam int unsigned W      = 16;
    localparam int unsigned BC     = 4;
    localparam int          FrameN = 2 * W * BC;

    logic        mclk;
    logic        reset;
    logic [15:0] s_left, s_right;
    logic        s_valid;
    logic        s_ready, sclk, ws, sdata, underrun;

    int checks = 0;
    int errors = 0;
    bit src_on = 1'b0;
    int src_idx = 0;

    pcm_serial_tx #(
        .WIDTH      (W),
        .BIT_CYCLES (BC)
    ) dut (
        .mclk     (mclk),
        .reset    (reset),
        .s_left   (s_left),
        .s_right  (s_right),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .sclk     (sclk),
        .ws       (ws),
        .sdata    (sdata),
        .underrun (underrun)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one mclk; the streaming source advances its pattern after each accepted pair.
    task automatic step();
        logic xfer;
        xfer = s_valid && s_ready;
        @(posedge mclk);
        #1;
        if (src_on) begin
            if (xfer) src_idx++;
            s_valid = 1'b1;
            s_left  = sample_t'(src_idx);
            s_right = sample_t'(0 - src_idx);
        end
    endtask

    // Receiver model: capture sdata/ws on each sclk rising edge over one frame of mclk cycles.
    task automatic run_frame(output logic [15:0] l, output logic [15:0] r, output int rises,
                             output int ws_bad, output int und, output int rdy,
                             output logic last_ws);
        logic prev;
        l = '0; r = '0; rises = 0; ws_bad = 0; und = 0; rdy = 0; prev = 1'b0; last_ws = 1'b0;
        for (int i = 0; i < FrameN; i++) begin
            if (underrun === 1'b1) und++;
            if (s_ready === 1'b1) rdy++;
            if (sclk === 1'b1 && prev === 1'b0) begin
                if (rises < W) begin
                    l = {l[14:0], sdata};
                    if (ws !== 1'b0) ws_bad++;
                end else begin
                    r = {r[14:0], sdata};
                    if (ws !== 1'b1) ws_bad++;
                end
                rises++;
            end
            prev = sclk;
            if (i == FrameN - 1) last_ws = ws;
            step();
        end
    endtask

    function automatic logic [31:0] pins();
        return {27'd0, sclk, ws, sdata, s_ready, underrun};
    endfunction

    logic [15:0] fl, fr, el, er, fk, nk;
    int          rises, ws_bad, und, rdy;
    logic        last_ws, prev_lsb;

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        for (int i = 0; i < 3; i++) step();
        chk("reset_state", pins(), 32'b00010);
        reset = 1'b0;
        s_left = 16'hDEAD; s_right = 16'hBEEF;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle", pins(), 32'b00010);
        end

        // Single pair
        s_valid = 1'b1; s_left = 16'hA5C3; s_right = 16'h8001;
        step();
        chk("accept_ready_low", {31'd0, s_ready}, 32'd0);
        chk("accept_still_idle", {29'd0, sclk, ws, sdata}, 32'd0);
        s_valid = 1'b0; s_left = 16'h1234; s_right = 16'h5678;
        step();
`ifdef PCM_TX_I2S_DELAY_EN
        chk("first_slot", {30'd0, ws, sdata}, 32'b00);
`else
        chk("first_slot", {30'd0, ws, sdata}, 32'b01);
`endif
        chk("ready_after_load", {31'd0, s_ready}, 32'd1);
        run_frame(fl, fr, rises, ws_bad, und, rdy, last_ws);
`ifdef PCM_TX_I2S_DELAY_EN
        chk("pair_left", {16'd0, fl}, 32'h52E1);
        chk("pair_right", {16'd0, fr}, 32'hC000);
`else
        chk("pair_left", {16'd0, fl}, 32'hA5C3);
        chk("pair_right", {16'd0, fr}, 32'h8001);
`endif
        chk("pair_rises", rises, 32);
        chk("pair_ws", ws_bad, 0);
        chk("pair_underrun", und, 0);
        chk("pair_ready", rdy, FrameN);
        chk("pair_end_ws", {31'd0, last_ws}, 32'd1);
        chk("next_frame_ws", {31'd0, ws}, 32'd0);
        chk("underrun_pulse", {31'd0, underrun}, 32'd1);
        run_frame(fl, fr, rises, ws_bad, und, rdy, last_ws);
`ifdef PCM_TX_I2S_DELAY_EN
        chk("zero_left", {16'd0, fl}, 32'h8000);
`else
        chk("zero_left", {16'd0, fl}, 32'h0000);
`endif
        chk("zero_right", {16'd0, fr}, 32'h0000);
        chk("zero_underrun_once", und, 1);
        chk("zero_sclk_runs", rises, 32);
        chk("zero_ws", ws_bad, 0);

        // Back-to-back streaming
        reset = 1'b1;
        step();
        chk("reset_again", pins(), 32'b00010);
        reset = 1'b0;
        src_idx = 1; src_on = 1'b1;
        s_valid = 1'b1; s_left = 16'h0001; s_right = 16'hFFFF;
        step();
        step();
        prev_lsb = 1'b0;
        for (int f = 1; f <= 8; f++) begin
            run_frame(fl, fr, rises, ws_bad, und, rdy, last_ws);
            fk = 16'(f);
            nk = 16'(0 - f);
`ifdef PCM_TX_I2S_DELAY_EN
            el = {prev_lsb, fk[15:1]};
            er = {fk[0], nk[15:1]};
            prev_lsb = nk[0];
`else
            el = fk;
            er = nk;
`endif
            chk($sformatf("stream%0d_left", f), {16'd0, fl}, {16'd0, el});
            chk($sformatf("stream%0d_right", f), {16'd0, fr}, {16'd0, er});
            chk($sformatf("stream%0d_underrun", f), und, 0);
            chk($sformatf("stream%0d_ready", f), rdy, 1);
            chk($sformatf("stream%0d_rises", f), rises, 32);
            chk($sformatf("stream%0d_ws", f), ws_bad, 0);
        end
        src_on = 1'b0; s_valid = 1'b0;

        // Reset in the middle of right-word bit 7 (pair 9 = 0009/FFF7)
        for (int i = 0; i < 94; i++) step();
        chk("mid_right_bit7", {29'd0, sclk, ws, sdata}, 32'b111);
        reset = 1'b1;
        step();
        chk("mid_reset", pins(), 32'b00010);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("post_reset_idle", pins(), 32'b00010);
        s_valid = 1'b1; s_left = 16'h8000; s_right = 16'h0000;
        step();
        s_valid = 1'b0;
        step();
        chk("restart_ws", {31'd0, ws}, 32'd0);
        run_frame(fl, fr, rises, ws_bad, und, rdy, last_ws);
`ifdef PCM_TX_I2S_DELAY_EN
        chk("restart_left", {16'd0, fl}, 32'h4000);
`else
        chk("restart_left", {16'd0, fl}, 32'h8000);
`endif
        chk("restart_right", {16'd0, fr}, 32'h0000);
        chk("restart_ws_bad", ws_bad, 0);
        chk("restart_underrun", und, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
